// File: rtl/proc_chain_scheduler_pkg.sv
// Shared types and defaults for the processA -> processB -> processC chain scheduler.
// Holds the stage FSM encoding and the small helpers used by the top and its tag queues.
package proc_chain_scheduler_pkg;

  localparam int unsigned BxWDefault     = 2;
  localparam int unsigned AbPagesDefault = 2;
  localparam int unsigned AcPagesDefault = 4;
  localparam int unsigned BcPagesDefault = 2;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } stage_state_e;

  // Pointer width for a page count; a single page still needs one bit of port.
  function automatic int unsigned ptr_w(input int unsigned pages);
    return (pages > 1) ? $clog2(pages) : 1;
  endfunction

  // Common IDLE/RUN behaviour of every HLS stage handshake.
  function automatic stage_state_e stage_next(input stage_state_e st, input logic launch,
                                              input logic done);
    stage_state_e nxt;
    nxt = st;
    case (st)
      StIdle:  nxt = launch ? StRun : StIdle;
      StRun:   nxt = done ? StIdle : StRun;
      default: nxt = StIdle;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/proc_chain_scheduler_tag_fifo.sv
// BX tag queue: power-of-two depth, simultaneous push/pop allowed, head visible combinationally.
// Storage is reset so the head reads 0 while the queue is empty after reset.
module proc_chain_scheduler_tag_fifo
  import proc_chain_scheduler_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 2,
  localparam int unsigned PtrW = ptr_w(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_en, rd_en;

  always_comb begin
    rd_en   = pop_i && (count_q != '0);
    // A full queue still accepts a push when the head leaves on the same edge.
    wr_en   = push_i && ((count_q != CntW'(Depth)) || rd_en);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (rd_en) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/proc_chain_scheduler.sv
// Sequences processA/B/C via ap_start/ap_done and owns the AB/AC/BC ping-pong page pointers.
// BX tags travel through per-buffer queues so several events can be in flight at once.
module proc_chain_scheduler
  import proc_chain_scheduler_pkg::*;
#(
  parameter int unsigned BX_W     = BxWDefault,
  parameter int unsigned AB_PAGES = AbPagesDefault,
  parameter int unsigned AC_PAGES = AcPagesDefault,
  parameter int unsigned BC_PAGES = BcPagesDefault,
  localparam int unsigned AbPw = ptr_w(AB_PAGES),
  localparam int unsigned AcPw = ptr_w(AC_PAGES),
  localparam int unsigned BcPw = ptr_w(BC_PAGES),
  localparam int unsigned AbCw = $clog2(AB_PAGES + 1),
  localparam int unsigned AcCw = $clog2(AC_PAGES + 1),
  localparam int unsigned BcCw = $clog2(BC_PAGES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            evt_valid,
  input  logic [BX_W-1:0] evt_bx,
  output logic            evt_ready,
  output logic            a_start,
  output logic            b_start,
  output logic            c_start,
  input  logic            a_done,
  input  logic            b_done,
  input  logic            c_done,
  output logic [BX_W-1:0] a_bx,
  output logic [BX_W-1:0] b_bx,
  output logic [BX_W-1:0] c_bx,
  output logic [AbPw-1:0] ab_wpage,
  output logic [AbPw-1:0] ab_rpage,
  output logic [AcPw-1:0] ac_wpage,
  output logic [AcPw-1:0] ac_rpage,
  output logic [BcPw-1:0] bc_wpage,
  output logic [BcPw-1:0] bc_rpage,
  output logic            out_valid,
  output logic [BX_W-1:0] out_bx,
  output logic            busy,
  output logic            drop_err
);

  stage_state_e a_st_q, a_st_d;
  stage_state_e b_st_q, b_st_d;
  stage_state_e c_st_q, c_st_d;

  logic [BX_W-1:0] a_bx_q, a_bx_d;
  logic [AbPw-1:0] ab_wpage_q, ab_wpage_d, ab_rpage_q, ab_rpage_d;
  logic [AcPw-1:0] ac_wpage_q, ac_wpage_d, ac_rpage_q, ac_rpage_d;
  logic [BcPw-1:0] bc_wpage_q, bc_wpage_d, bc_rpage_q, bc_rpage_d;
  logic            out_valid_q, out_valid_d;
  logic [BX_W-1:0] out_bx_q, out_bx_d;
  logic            drop_err_q, drop_err_d;

  logic            a_run, b_run, c_run;
  logic            a_fin, b_fin, c_fin;
  logic            evt_acc, b_launch, c_launch;
  logic [AbCw-1:0] occ_ab;
  logic [AcCw-1:0] occ_ac;
  logic [BcCw-1:0] occ_bc;
  logic [BX_W-1:0] qab_head, qac_head, qbc_head;

  // Occupancy of each buffer is exactly the number of tags waiting in its queue.
  proc_chain_scheduler_tag_fifo #(
    .Depth (AB_PAGES),
    .Width (BX_W)
  ) u_q_ab (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (a_fin),
    .data_i  (a_bx_q),
    .pop_i   (b_fin),
    .head_o  (qab_head),
    .count_o (occ_ab)
  );

  proc_chain_scheduler_tag_fifo #(
    .Depth (AC_PAGES),
    .Width (BX_W)
  ) u_q_ac (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (a_fin),
    .data_i  (a_bx_q),
    .pop_i   (c_fin),
    .head_o  (qac_head),
    .count_o (occ_ac)
  );

  proc_chain_scheduler_tag_fifo #(
    .Depth (BC_PAGES),
    .Width (BX_W)
  ) u_q_bc (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (b_fin),
    .data_i  (qab_head),
    .pop_i   (c_fin),
    .head_o  (qbc_head),
    .count_o (occ_bc)
  );

  // Launch decisions use registered occupancy, so a completion frees space one cycle later.
  always_comb begin
    a_run     = (a_st_q == StRun);
    b_run     = (b_st_q == StRun);
    c_run     = (c_st_q == StRun);
    a_fin     = a_run && a_done;
    b_fin     = b_run && b_done;
    c_fin     = c_run && c_done;
    evt_ready = !a_run && (occ_ab < AbCw'(AB_PAGES)) && (occ_ac < AcCw'(AC_PAGES));
    evt_acc   = evt_valid && evt_ready;
    b_launch  = !b_run && (occ_ab != '0) && (occ_bc < BcCw'(BC_PAGES));
    c_launch  = !c_run && (occ_bc != '0) && (occ_ac != '0);
  end

  always_comb begin
    a_st_d      = stage_next(a_st_q, evt_acc, a_done);
    b_st_d      = stage_next(b_st_q, b_launch, b_done);
    c_st_d      = stage_next(c_st_q, c_launch, c_done);
    a_bx_d      = evt_acc ? evt_bx : a_bx_q;
    ab_wpage_d  = ab_wpage_q + AbPw'(a_fin);
    ac_wpage_d  = ac_wpage_q + AcPw'(a_fin);
    ab_rpage_d  = ab_rpage_q + AbPw'(b_fin);
    bc_wpage_d  = bc_wpage_q + BcPw'(b_fin);
    bc_rpage_d  = bc_rpage_q + BcPw'(c_fin);
    ac_rpage_d  = ac_rpage_q + AcPw'(c_fin);
    out_valid_d = c_fin;
    out_bx_d    = c_fin ? qbc_head : out_bx_q;
    drop_err_d  = drop_err_q || (evt_valid && !evt_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_st_q      <= StIdle;
      b_st_q      <= StIdle;
      c_st_q      <= StIdle;
      a_bx_q      <= '0;
      ab_wpage_q  <= '0;
      ab_rpage_q  <= '0;
      ac_wpage_q  <= '0;
      ac_rpage_q  <= '0;
      bc_wpage_q  <= '0;
      bc_rpage_q  <= '0;
      out_valid_q <= 1'b0;
      out_bx_q    <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      a_st_q      <= a_st_d;
      b_st_q      <= b_st_d;
      c_st_q      <= c_st_d;
      a_bx_q      <= a_bx_d;
      ab_wpage_q  <= ab_wpage_d;
      ab_rpage_q  <= ab_rpage_d;
      ac_wpage_q  <= ac_wpage_d;
      ac_rpage_q  <= ac_rpage_d;
      bc_wpage_q  <= bc_wpage_d;
      bc_rpage_q  <= bc_rpage_d;
      out_valid_q <= out_valid_d;
      out_bx_q    <= out_bx_d;
      drop_err_q  <= drop_err_d;
    end
  end

  // In-order flow through B keeps the AC and BC queue heads describing the same event.
  ac_order_a : assert property (@(posedge clk) disable iff (reset) c_fin |-> qac_head == qbc_head);

  assign a_start   = a_run;
  assign b_start   = b_run;
  assign c_start   = c_run;
  assign a_bx      = a_bx_q;
  assign b_bx      = qab_head;
  assign c_bx      = qbc_head;
  assign ab_wpage  = ab_wpage_q;
  assign ab_rpage  = ab_rpage_q;
  assign ac_wpage  = ac_wpage_q;
  assign ac_rpage  = ac_rpage_q;
  assign bc_wpage  = bc_wpage_q;
  assign bc_rpage  = bc_rpage_q;
  assign out_valid = out_valid_q;
  assign out_bx    = out_bx_q;
  assign busy      = a_run || b_run || c_run || (occ_ab != '0) || (occ_ac != '0) || (occ_bc != '0);
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_proc_chain_scheduler.sv
// Directed and randomized bench for proc_chain_scheduler against an event-level queue model.
module tb_proc_chain_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       evt_valid;
  logic [1:0] evt_bx;
  logic       evt_ready;
  logic       a_start, b_start, c_start;
  logic       a_done, b_done, c_done;
  logic [1:0] a_bx, b_bx, c_bx;
  logic [0:0] ab_wpage, ab_rpage;
  logic [1:0] ac_wpage, ac_rpage;
  logic [0:0] bc_wpage, bc_rpage;
  logic       out_valid;
  logic [1:0] out_bx;
  logic       busy;
  logic       drop_err;

  always #5 clk = ~clk;

  proc_chain_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .evt_valid (evt_valid),
    .evt_bx    (evt_bx),
    .evt_ready (evt_ready),
    .a_start   (a_start),
    .b_start   (b_start),
    .c_start   (c_start),
    .a_done    (a_done),
    .b_done    (b_done),
    .c_done    (c_done),
    .a_bx      (a_bx),
    .b_bx      (b_bx),
    .c_bx      (c_bx),
    .ab_wpage  (ab_wpage),
    .ab_rpage  (ab_rpage),
    .ac_wpage  (ac_wpage),
    .ac_rpage  (ac_rpage),
    .bc_wpage  (bc_wpage),
    .bc_rpage  (bc_rpage),
    .out_valid (out_valid),
    .out_bx    (out_bx),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  // Reference model: which stages run, plus one tag queue per buffer.
  bit m_a, m_b, m_c, m_ov, m_drop;
  int m_abx, m_obx;
  int q_ab[$], q_ac[$], q_bc[$], exp_order[$];
  int p_abw, p_abr, p_acw, p_acr, p_bcw, p_bcr;

  bit hold_a, hold_b, hold_c, rand_dly;
  int dly_a, dly_b, dly_c, cnt_a, cnt_b, cnt_c;
  int n_vec = 0, n_err = 0, outs_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return !m_a && (q_ab.size() < 2) && (q_ac.size() < 4);
  endfunction

  function automatic bit m_busy();
    return m_a || m_b || m_c || (q_ab.size() != 0) || (q_ac.size() != 0) || (q_bc.size() != 0);
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_c = 0; m_ov = 0; m_drop = 0; m_abx = 0; m_obx = 0;
    q_ab.delete(); q_ac.delete(); q_bc.delete(); exp_order.delete();
    p_abw = 0; p_abr = 0; p_acw = 0; p_acr = 0; p_bcw = 0; p_bcr = 0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
  endtask

  task automatic model_step();
    bit acc, bl, cl, af, bf, cf;
    int bhead;
    acc = evt_valid && m_ready();
    if (evt_valid && !m_ready()) m_drop = 1;
    bl = !m_b && (q_ab.size() > 0) && (q_bc.size() < 2);
    cl = !m_c && (q_bc.size() > 0) && (q_ac.size() > 0);
    af = m_a && a_done;
    bf = m_b && b_done;
    cf = m_c && c_done;
    bhead = bf ? q_ab[0] : 0;
    m_ov = cf;
    if (cf) m_obx = q_bc[0];
    if (af) begin
      q_ab.push_back(m_abx); q_ac.push_back(m_abx);
      p_abw = (p_abw + 1) % 2; p_acw = (p_acw + 1) % 4;
    end
    if (bf) begin
      void'(q_ab.pop_front()); q_bc.push_back(bhead);
      p_abr = (p_abr + 1) % 2; p_bcw = (p_bcw + 1) % 2;
    end
    if (cf) begin
      void'(q_bc.pop_front()); void'(q_ac.pop_front());
      p_bcr = (p_bcr + 1) % 2; p_acr = (p_acr + 1) % 4;
    end
    if (acc) begin
      m_abx = int'(evt_bx);
      exp_order.push_back(int'(evt_bx));
    end
    m_a = m_a ? !a_done : acc;
    m_b = m_b ? !b_done : bl;
    m_c = m_c ? !c_done : cl;
  endtask

  task automatic check_outputs();
    int e;
    chk("evt_ready", evt_ready, m_ready());
    chk("a_start", a_start, m_a);
    chk("b_start", b_start, m_b);
    chk("c_start", c_start, m_c);
    if (m_a) chk("a_bx", a_bx, m_abx);
    if (m_b) chk("b_bx", b_bx, q_ab[0]);
    if (m_c) chk("c_bx", c_bx, q_bc[0]);
    chk("ab_wpage", ab_wpage, p_abw);
    chk("ab_rpage", ab_rpage, p_abr);
    chk("ac_wpage", ac_wpage, p_acw);
    chk("ac_rpage", ac_rpage, p_acr);
    chk("bc_wpage", bc_wpage, p_bcw);
    chk("bc_rpage", bc_rpage, p_bcr);
    chk("out_valid", out_valid, m_ov);
    chk("busy", busy, m_busy());
    chk("drop_err", drop_err, m_drop);
    if (out_valid === 1'b1) outs_seen++;
    if (m_ov) begin
      chk("out_bx", out_bx, m_obx);
      if (exp_order.size() > 0) begin
        e = exp_order.pop_front();
        chk("out_order", out_bx, e);
      end
    end
  endtask

  // Each stage answers ap_done a set number of cycles after its start, unless held.
  task automatic drive_dones();
    cnt_a = m_a ? cnt_a + 1 : 0;
    cnt_b = m_b ? cnt_b + 1 : 0;
    cnt_c = m_c ? cnt_c + 1 : 0;
    if (rand_dly && cnt_a == 1) dly_a = $urandom_range(1, 10);
    if (rand_dly && cnt_b == 1) dly_b = $urandom_range(1, 10);
    if (rand_dly && cnt_c == 1) dly_c = $urandom_range(1, 10);
    a_done = m_a && (cnt_a >= dly_a) && !hold_a;
    b_done = m_b && (cnt_b >= dly_b) && !hold_b;
    c_done = m_c && (cnt_c >= dly_c) && !hold_c;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    drive_dones();
  endtask

  task automatic send(input int bx);
    evt_valid = 1'b1;
    evt_bx    = 2'(bx);
    cycle();
    evt_valid = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (m_busy() && k < limit) begin
      cycle();
      k++;
    end
    chk("drain_timeout", m_busy(), 0);
    chk("drain_busy", busy, 0);
  endtask

  task automatic wait_ready(input int limit);
    int k = 0;
    while (!m_ready() && k < limit) begin
      cycle();
      k++;
    end
    chk("ready_timeout", m_ready(), 1);
  endtask

  // Asserted away from any clock edge to exercise the asynchronous path.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_a_start", a_start, 0);
    chk("rst_b_start", b_start, 0);
    chk("rst_c_start", c_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ac_wpage", ac_wpage, 0);
    chk("rst_drop_err", drop_err, 0);
    model_reset();
    hold_a = 0; hold_b = 0; hold_c = 0;
    evt_valid = 1'b0; a_done = 1'b0; b_done = 1'b0; c_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("ready_after_reset", evt_ready, 1);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int base;
    reset = 1'b1; evt_valid = 1'b0; evt_bx = '0;
    a_done = 1'b0; b_done = 1'b0; c_done = 1'b0;
    hold_a = 0; hold_b = 0; hold_c = 0; rand_dly = 0;
    dly_a = 5; dly_b = 5; dly_c = 5;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    chk("ready_initial", evt_ready, 1);

    // Stray dones while every stage is idle must be ignored.
    a_done = 1'b1; b_done = 1'b1; c_done = 1'b1;
    cycle();

    // Single event walks A -> B -> C on page 0.
    send(2);
    drain(100);

    // B held: two events fill AB, a third is dropped, then B is released.
    hold_b = 1;
    send(0); run(8);
    send(1); run(8);
    chk("ready_ab_full", evt_ready, 0);
    send(2);
    chk("drop_err_set", drop_err, 1);
    hold_b = 0;
    drain(200);
    send(3);
    drain(100);

    // C held: AC pages fill 0..3 and the write pointer wraps without overrun.
    async_reset();
    hold_c = 1;
    for (int i = 0; i < 4; i++) begin
      send(i); run(12);
    end
    chk("ready_ac_stall", evt_ready, 0);
    chk("ac_wpage_wrap", ac_wpage, 0);
    hold_c = 0;
    drain(300);

    // a_done and b_done on the same edge: AB occupancy unchanged, B relaunches next cycle.
    dly_a = 2; dly_b = 2; dly_c = 2;
    hold_b = 1;
    send(1); run(6);
    hold_a = 1;
    send(3); run(4);
    hold_a = 0; hold_b = 0;
    drive_dones();
    cycle();
    chk("b_gap_after_done", b_start, 0);
    cycle();
    chk("b_relaunch", b_start, 1);
    drain(100);

    // Random done delays over eight events; completion order must match acceptance.
    rand_dly = 1;
    base = outs_seen;
    for (int i = 0; i < 8; i++) begin
      wait_ready(200);
      send(int'($urandom_range(0, 3)));
      run(int'($urandom_range(0, 3)));
    end
    drain(400);
    chk("random_out_count", outs_seen - base, 8);
    rand_dly = 0;

    // Reset with all three stages running.
    dly_a = 2; dly_b = 2; dly_c = 2;
    hold_c = 1;
    send(0); run(12);
    hold_b = 1;
    send(1); run(8);
    hold_a = 1;
    send(2); run(3);
    chk("all_run_a", a_start, 1);
    chk("all_run_b", b_start, 1);
    chk("all_run_c", c_start, 1);
    async_reset();
    send(1);
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/proc_chain_scheduler.md
Name: proc_chain_scheduler

Overview:
- Sequences the three HLS stages (processA -> processB -> processC) through their ap_start/ap_done handshakes.
- Manages page ownership of the inter-stage ping-pong BRAMs: AB with 2 pages, AC with 4 pages, BC with 2 pages.
- Carries each event's BX tag to every stage so several BXs are in flight at once without page overwrite.
- Sits in the project top level, between the event source and the processA/B/C instances.

Parameters:
- BX_W, 2, width of the BX tag.
- AB_PAGES, 2, page count of the A->B buffer (power of 2).
- AC_PAGES, 4, page count of the A->C buffer (power of 2).
- BC_PAGES, 2, page count of the B->C buffer (power of 2).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- evt_valid  in  1  new event request.
- evt_bx  in  BX_W  BX of the new event.
- evt_ready  out  1  event accepted when evt_valid && evt_ready.
- a_start, b_start, c_start  out  1 each  ap_start to each stage.
- a_done, b_done, c_done  in  1 each  ap_done from each stage, one-cycle pulse.
- a_bx, b_bx, c_bx  out  BX_W each  bx_V to each stage, stable while that stage's start is high.
- ab_wpage, ab_rpage  out  log2(AB_PAGES)  A write page / B read page.
- ac_wpage, ac_rpage  out  log2(AC_PAGES)  A write page / C read page.
- bc_wpage, bc_rpage  out  log2(BC_PAGES)  B write page / C read page.
- out_valid  out  1  pulse when C completes an event.
- out_bx  out  BX_W  BX of the completed event, valid with out_valid.
- busy  out  1  any stage running or any buffer occupied.
- drop_err  out  1  sticky: evt_valid seen while evt_ready=0.

Behaviour:
- Reset (async, immediate): all outputs 0, all occupancy counters 0, all page pointers 0, BX queues empty, every stage in IDLE.
- Per-stage FSM, identical for A/B/C, states IDLE and RUN:
  - IDLE->RUN when its launch condition holds; start goes high on the next edge.
  - In RUN, start is held high until done is sampled high. That edge returns the stage to IDLE and drops start the same edge.
  - done while IDLE is ignored.
- Occupancy counters: occ_ab in 0..AB_PAGES, occ_ac in 0..AC_PAGES, occ_bc in 0..BC_PAGES. A simultaneous inc and dec on one counter nets zero.
- A launch:
  - evt_ready = A IDLE && occ_ab<AB_PAGES && occ_ac<AC_PAGES (combinational).
  - On accept, latch evt_bx into a_bx.
  - On a_done: occ_ab++, occ_ac++, ab_wpage++ and ac_wpage++ (modulo wrap), and push a_bx into queues qAB (depth AB_PAGES) and qAC (depth AC_PAGES).
- B launch:
  - Condition: B IDLE && occ_ab>0 && occ_bc<BC_PAGES.
  - b_bx = head of qAB.
  - On b_done: pop qAB, occ_ab--, ab_rpage++, occ_bc++, bc_wpage++, push b_bx into qBC.
- C launch:
  - Condition: C IDLE && occ_bc>0 && occ_ac>0.
  - c_bx = head of qBC. The head of qAC must equal it; ordering guarantees this.
  - On c_done: pop qBC and qAC, occ_bc--, occ_ac--, bc_rpage++, ac_rpage++.
  - Next cycle: out_valid=1 for exactly one cycle with out_bx = c_bx.
- Latency: start rises one cycle after its launch condition. Start-to-start across stages is at least done+1.
- Same-cycle a_done and B launch: B launch is evaluated on the pre-update occupancy, so it launches one cycle later. The same rule applies to C.
- Wrap-around: page pointers roll modulo the page count. The occupancy limits prevent a writer from reaching a page the reader has not released.
- drop_err: set when evt_valid && !evt_ready. Cleared only by reset. The dropped event has no other effect.
- busy = any stage in RUN || any occ_* != 0.
- Reset mid-operation: aborts everything immediately. The stages share the same reset; no completion is reported.

Decomposition:
- Shared package: the BX_W default, the page-count constants, and the stage FSM state encoding (IDLE/RUN).
- One natural sub-module: tag_fifo, a parameterised depth/width BX queue with push, pop, head, count. It is instantiated three times (qAB, qAC, qBC).

Test Plan:
- Single event, bx=2, each done returning 5 cycles after start:
  - a_start, b_start, c_start fire in sequence, all with bx=2, pages all 0.
  - out_valid with out_bx=2; afterwards busy=0 and all occ_* are 0.
- Back-to-back events bx=0,1,2 with B held (b_done withheld):
  - After two A completions, evt_ready=0 because occ_ab=2.
  - Third evt_valid sets drop_err=1.
  - Releasing b_done resumes A.
- Stall C (c_done withheld), then feed bx=0,1,2,3:
  - A blocks on occ_bc/occ_ab back-pressure.
  - ac_wpage takes 0,1,2,3 in order, with no overwrite of unread pages.
- Simultaneous a_done and b_done on the same cycle:
  - occ_ab is unchanged net, occ_bc increments.
  - The next B launch occurs the following cycle.
- Eight events with random done delays (1..10 cycles):
  - out_bx sequence equals the input order.
  - Pointers wrap correctly (ab_rpage 0,1,0,1...).
- Assert reset while all three stages are in RUN:
  - All starts, out_valid and occ_* go to 0 asynchronously.
  - evt_ready=1 on the first cycle after reset release.
